// File: rtl/bp_fe_bht_update_queue_if.sv
// Enqueue handshake between the backend resolution path
// and the BHT update queue.
interface bp_fe_bht_update_queue_if #(
    parameter int idx_width_p = 9
);
    logic                   v;
    logic [idx_width_p-1:0] idx;
    logic                   correct;
    logic                   ready;

    modport master (
        output v, idx, correct,
        input  ready
    );

    modport slave (
        input  v, idx, correct,
        output ready
    );
endinterface

// File: rtl/bp_fe_bht_update_queue.sv
// FIFO of branch-resolution updates feeding the BHT write port.
// Defers a head write that collides with the current BHT read index.
module bp_fe_bht_update_queue #(
    parameter int bht_idx_width_p = 9,
    parameter int els_p           = 4,
    parameter int max_defer_p     = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    bp_fe_bht_update_queue_if.slave    enq_i,
    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] idx_r_i,
    output logic                       w_v_o,
    output logic [bht_idx_width_p-1:0] idx_w_o,
    output logic                       correct_w_o,
    output logic [$clog2(els_p):0]     count_o
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;
    localparam int def_w_lp = $clog2(max_defer_p + 1);

    logic [bht_idx_width_p-1:0] idx_mem_q  [els_p];
    logic                       corr_mem_q [els_p];

    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic [def_w_lp-1:0] defer_q, defer_d;

    logic                       empty;
    logic                       enq;
    logic                       conflict;
    logic                       forced;
    logic [bht_idx_width_p-1:0] head_idx;
    logic                       head_corr;

    assign empty     = (count_q == '0);
    assign head_idx  = idx_mem_q[rptr_q];
    assign head_corr = corr_mem_q[rptr_q];

    // Ready is a pure function of occupancy, so a full queue
    // refuses input even while it drains.
    assign enq_i.ready = (count_q != cnt_w_lp'(els_p));
    assign enq         = enq_i.v & enq_i.ready;

    assign conflict = ~empty & r_v_i & (idx_r_i == head_idx);
    assign forced   = (defer_q == def_w_lp'(max_defer_p));

    assign w_v_o       = ~empty & (~conflict | forced);
    assign idx_w_o     = empty ? '0 : head_idx;
    assign correct_w_o = ~empty & head_corr;
    assign count_o     = count_q;

    // Next-state for pointers, occupancy and defer counter.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        defer_d = defer_q;

        if (enq) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (w_v_o) begin
            rptr_d = rptr_q + 1'b1;
        end

        unique case ({enq, w_v_o})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (w_v_o || empty) begin
            defer_d = '0;
        end else if (conflict) begin
            defer_d = defer_q + 1'b1;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            defer_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            defer_q <= defer_d;
        end
    end

    // Entry storage; reset only needs to clear the pointers.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            idx_mem_q[wptr_q]  <= enq_i.idx;
            corr_mem_q[wptr_q] <= enq_i.correct;
        end
    end

endmodule
